cam_wr_addr_gen: RTL
====================

// Module: cam_wr_addr_gen
// PURPOSE
//  Camera-side SDRAM write sequencer in the 133 MHz domain, downstream of the bank switcher.
//  Latches cam_bank at each camera frame start and issues BURST_LEN-word write bursts to the
//  SDRAM controller as the camera FIFO fills. Each burst carries a {bank, row, col} address.
//  When a frame completes, it pulses cam_frame_done, which drives the switcher's cam_rise input.
// PARAMETERS
//  BURST_LEN    256     words per write burst; power of 2, <= 2**COL_W
//  FRAME_WORDS  307200  16-bit words per frame (640x480); must be a multiple of BURST_LEN
//  BA_W         2       bank-select width (matches cam_bank)
//  ROW_W        13      SDRAM row address width
//  COL_W        9       SDRAM column address width
//  FIFO_CNT_W   11      width of the FIFO fill-level input
//  VS_POL       1       active level of cam_vsync (1: frame starts on rising edge)
// PORTS
//  clk             in   1                    133 MHz system clock
//  rst_133         in   1                    reset; asynchronous, active-low
//  cam_vsync       in   1                    raw camera vsync, pclk domain
//  cam_bank        in   BA_W                 bank to write next frame into, from bank switcher
//  fifo_rd_cnt     in   FIFO_CNT_W           words available in camera write FIFO
//  wr_req          out  1                    burst write request to SDRAM controller
//  wr_ack          in   1                    controller accepted request (1-cycle pulse)
//  wr_done         in   1                    controller finished burst (1-cycle pulse)
//  wr_addr         out  BA_W+ROW_W+COL_W     burst start address {bank, row, col}
//  cam_frame_done  out  1                    1-cycle pulse, frame fully written (to cam_rise)
//  wr_busy         out  1                    high from ARM until frame done/abort
// BEHAVIOUR
//  - Reset: wr_req=0, wr_addr=0, cam_frame_done=0, wr_busy=0, offset=0, state=IDLE, restart flag=0.
//  - vsync path: 2-flop synchronizer, then edge detect on the VS_POL edge.
//    Edge detect produces vs_evt 3 clk after the input edge.
//  - FSM:
//    - IDLE:  on vs_evt -> ARM.
//    - ARM (1 cycle): bank_lat<=cam_bank, offset<=0, wr_busy<=1 -> WAIT.
//    - WAIT:  if fifo_rd_cnt>=BURST_LEN -> REQ (wr_req rises the next cycle).
//    - REQ:   hold wr_req=1 and wr_addr stable until wr_ack; on wr_ack wr_req<=0 -> BUSY.
//    - BUSY:  on wr_done: offset+=BURST_LEN.
//      If new offset==FRAME_WORDS: -> DONE; else -> WAIT.
//    - DONE (1 cycle): cam_frame_done=1, wr_busy<=0 -> IDLE.
//  - wr_addr = {bank_lat, offset[ROW_W+COL_W-1:0]}; col=offset[COL_W-1:0], row=next ROW_W bits.
//  - wr_addr registered; valid whenever wr_req=1.
//  - cam_bank is sampled only in ARM; later cam_bank changes do not affect the current frame.
//  - vs_evt while wr_busy (frame overrun): set restart flag; no cam_frame_done for that frame.
//    - In WAIT: go to ARM next cycle.
//    - In REQ/BUSY: the accepted or pending burst completes normally (req never withdrawn).
//      After its wr_done -> ARM instead of WAIT/DONE.
//    - vs_evt coincident with the final wr_done: counts as overrun; no done pulse; -> ARM.
//  - vs_evt in DONE: -> ARM directly after the pulse (frame counted complete).
//  - wr_ack/wr_done outside REQ/BUSY: ignored.
//  - Reset mid-burst: all state cleared immediately; controller-side cleanup is the controller's job.
// CONFIGURATION
//  - CAM_FRAME_DROP_CNT_EN defined: adds output frame_drop_cnt[7:0].
//    - Reset 0; +1 per overrun abort; saturates at 255.
//  - Not defined: port and counter absent; overrun behaviour otherwise identical.
// TESTING  (bench params FRAME_WORDS=1024, BURST_LEN=256, BA_W=2, ROW_W=13, COL_W=9)
//  1. Assert rst_133 low mid-run -> all outputs 0 same cycle; no wr_req until next vsync.
//  2. Full frame: cam_bank=01, fifo_rd_cnt=256, ack +1 clk, done +4 clk.
//     -> 4 bursts at wr_addr 0x400000/0x400100/0x400200/0x400300.
//     -> exactly one cam_frame_done pulse, 1 clk after 4th wr_done.
//  3. fifo_rd_cnt=255 held -> wr_req stays 0.
//     -> raise to 256: wr_req=1 within 2 clk, held until wr_ack.
//  4. cam_bank 01->10 after first burst -> remaining bursts keep bank 01.
//     -> next frame's bursts use bank 10.
//  5. vsync edge during BUSY of burst 2 -> burst completes; no cam_frame_done.
//     -> next wr_addr = {cam_bank, 0}.
//  6. CAM_FRAME_DROP_CNT_EN: 3 overrun frames -> frame_drop_cnt=3.
//     -> 300 overruns: frame_drop_cnt=255.

Source files
------------

// File: rtl/cam_wr_addr_gen.sv
`timescale 1ns/1ps
// cam_wr_addr_gen: camera-side SDRAM burst write sequencer in the 133 MHz domain.
// Define CAM_FRAME_DROP_CNT_EN to add the saturating frame_drop_cnt overrun counter output.
module cam_wr_addr_gen #(
    parameter int BURST_LEN   = 256,
    parameter int FRAME_WORDS = 307200,
    parameter int BA_W        = 2,
    parameter int ROW_W       = 13,
    parameter int COL_W       = 9,
    parameter int FIFO_CNT_W  = 11,
    parameter bit VS_POL      = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_133,
    input  logic                        cam_vsync,
    input  logic [BA_W-1:0]             cam_bank,
    input  logic [FIFO_CNT_W-1:0]       fifo_rd_cnt,
    output logic                        wr_req,
    input  logic                        wr_ack,
    input  logic                        wr_done,
    output logic [BA_W+ROW_W+COL_W-1:0] wr_addr,
    output logic                        cam_frame_done,
    output logic                        wr_busy
`ifdef CAM_FRAME_DROP_CNT_EN
    ,
    output logic [7:0]                  frame_drop_cnt
`endif
);

    localparam int OFF_W      = ROW_W + COL_W;
    localparam int CNT_W      = OFF_W + 1;
    localparam int AW         = BA_W + OFF_W;
    localparam int FIFO_THR_W = FIFO_CNT_W + 1;

    localparam logic [CNT_W-1:0]      BURST_C  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]      FRAME_C  = CNT_W'(FRAME_WORDS);
    localparam logic [FIFO_THR_W-1:0] FIFO_THR = FIFO_THR_W'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_REQ,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       vs_sync_q;
    logic             vs_evt_q, vs_evt_d;
    logic [CNT_W-1:0] offset_q, offset_d, offset_next;
    logic [BA_W-1:0]  bank_q, bank_d;
    logic             restart_q, restart_d;
    logic             req_q, req_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             fifo_ok, last_burst;

    // NOTE: the synchronizer resets to the active level so a vsync already held active
    // when reset releases is not mistaken for a fresh frame start.
    always_ff @(posedge clk or negedge rst_133) begin
        if (!rst_133) begin
            vs_sync_q <= {3{VS_POL}};
            vs_evt_q  <= 1'b0;
        end else begin
            vs_sync_q <= {vs_sync_q[1:0], cam_vsync};
            vs_evt_q  <= vs_evt_d;
        end
    end

    assign vs_evt_d    = (vs_sync_q[1] == VS_POL) && (vs_sync_q[2] != VS_POL);
    assign fifo_ok     = {1'b0, fifo_rd_cnt} >= FIFO_THR;
    assign offset_next = offset_q + BURST_C;
    assign last_burst  = (offset_next == FRAME_C);

    always_ff @(posedge clk or negedge rst_133) begin
        if (!rst_133) begin
            state_q   <= S_IDLE;
            offset_q  <= '0;
            bank_q    <= '0;
            restart_q <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            bank_q    <= bank_d;
            restart_q <= restart_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // An overrun (vsync while a frame is in flight) never withdraws a posted request;
    // the pending burst finishes and the frame restarts from ARM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (vs_evt_q) state_d = S_ARM;
            S_ARM:  state_d = S_WAIT;
            S_WAIT: begin
                if (vs_evt_q)     state_d = S_ARM;
                else if (fifo_ok) state_d = S_REQ;
            end
            S_REQ:  if (wr_ack) state_d = S_BUSY;
            S_BUSY: begin
                if (wr_done) begin
                    if (restart_q || vs_evt_q) state_d = S_ARM;
                    else if (last_burst)       state_d = S_DONE;
                    else                       state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = vs_evt_q ? S_ARM : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every _d is given its hold value first so no path through the case infers a latch.
    always_comb begin
        offset_d  = offset_q;
        bank_d    = bank_q;
        restart_d = restart_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        req_d     = (state_d == S_REQ);
        done_d    = (state_d == S_DONE);
        unique case (state_q)
            S_ARM: begin
                bank_d    = cam_bank;
                offset_d  = '0;
                busy_d    = 1'b1;
                restart_d = 1'b0;
            end
            S_WAIT: begin
                if (state_d == S_REQ) addr_d = {bank_q, offset_q[OFF_W-1:0]};
            end
            S_REQ: begin
                if (vs_evt_q) restart_d = 1'b1;
            end
            S_BUSY: begin
                if (vs_evt_q) restart_d = 1'b1;
                if (wr_done)  offset_d  = offset_next;
            end
            S_DONE: busy_d = 1'b0;
            default: ;
        endcase
    end

    assign wr_req         = req_q;
    assign wr_addr        = addr_q;
    assign cam_frame_done = done_q;
    assign wr_busy        = busy_q;

`ifdef CAM_FRAME_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;
    logic       abort;

    assign abort  = (state_q == S_WAIT && vs_evt_q) ||
                    (state_q == S_BUSY && wr_done && (restart_q || vs_evt_q));
    assign drop_d = (abort && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    always_ff @(posedge clk or negedge rst_133) begin
        if (!rst_133) drop_q <= 8'd0;
        else          drop_q <= drop_d;
    end

    assign frame_drop_cnt = drop_q;
`endif

endmodule
